ctrl_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer that drives the 8-bit ALU: it issues `func` and operands, then consumes the result, zero flag and carry flag.
- Owns the program counter, instruction register and Z/C flag register.
- Fetches 16-bit instructions over a req/ack handshake and writes ALU results to the external register file.
- Sits between instruction memory, the register file and the ALU at the top of the CPU.

---
 rtl/ctrl_unit_pkg.sv | 77 +++++++
 rtl/ctrl_unit_decode.sv | 48 ++++
 rtl/ctrl_unit.sv | 166 ++++++++++++++++
 tb/tb_ctrl_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_unit_pkg.sv
// ctrl_unit_pkg: definitions shared by the control sequencer, its decoder
// and the ALU.
//   - instruction field positions and extract helpers
//   - opcode constants (OP_ADI .. OP_HLT)
//   - ALU function codes, shared with the ALU
//   - sequencer state enum and branch condition enum
package ctrl_unit_pkg;

    localparam int INSTR_W = 16;

    // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Opcodes. 0x0-0x7 are ALU ops whose low three bits are the ALU func.
    localparam logic [3:0] OP_ADI = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BRZ = 4'h9;
    localparam logic [3:0] OP_BRC = 4'hA;
    localparam logic [3:0] OP_NOP = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hC;

    // ALU function select. ADI adds the immediate (A) to register B.
    localparam logic [2:0] FN_ADI = 3'd0;
    localparam logic [2:0] FN_ADD = 3'd1;
    localparam logic [2:0] FN_SUB = 3'd2;
    localparam logic [2:0] FN_AND = 3'd3;
    localparam logic [2:0] FN_OR  = 3'd4;
    localparam logic [2:0] FN_XOR = 3'd5;
    localparam logic [2:0] FN_SHL = 3'd6;
    localparam logic [2:0] FN_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    // Condition under which a control-flow op loads PC from imm.
    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_ALWAYS = 2'd1,
        BR_Z      = 2'd2,
        BR_C      = 2'd3
    } br_cond_e;

    function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] ins);
        return ins[OP_HI:OP_LO];
    endfunction

    function automatic logic [1:0] instr_rd(input logic [INSTR_W-1:0] ins);
        return ins[RD_HI:RD_LO];
    endfunction

    function automatic logic [1:0] instr_rs(input logic [INSTR_W-1:0] ins);
        return ins[RS_HI:RS_LO];
    endfunction

    function automatic logic [7:0] instr_imm(input logic [INSTR_W-1:0] ins);
        return ins[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/ctrl_unit_decode.sv
// ctrl_decode: combinational opcode classifier.
//   op_i          opcode field of the instruction register
//   is_alu_o      op 0x0-0x7, result written back and flags updated
//   is_branch_o   JMP / BRZ / BRC
//   branch_cond_o condition for loading PC from imm
//   is_halt_o     HLT
//   is_illegal_o  op 0xD-0xF (executed as NOP)
module ctrl_decode
    import ctrl_unit_pkg::*;
(
    input  logic [3:0] op_i,
    output logic       is_alu_o,
    output logic       is_branch_o,
    output br_cond_e   branch_cond_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    always_comb begin
        is_alu_o      = 1'b0;
        is_branch_o   = 1'b0;
        branch_cond_o = BR_NONE;
        is_halt_o     = 1'b0;
        is_illegal_o  = 1'b0;
        if (!op_i[3]) begin
            is_alu_o = 1'b1;
        end else begin
            case (op_i)
                OP_JMP: begin
                    is_branch_o   = 1'b1;
                    branch_cond_o = BR_ALWAYS;
                end
                OP_BRZ: begin
                    is_branch_o   = 1'b1;
                    branch_cond_o = BR_Z;
                end
                OP_BRC: begin
                    is_branch_o   = 1'b1;
                    branch_cond_o = BR_C;
                end
                OP_NOP:  ;
                OP_HLT:  is_halt_o    = 1'b1;
                default: is_illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle FETCH -> DECODE -> EXEC sequencer driving the ALU.
// Owns PC, IR, operand registers A/B and the Z/C flags.
//   clk_i, rst_ni           clock, async active-low reset
//   imem_req/addr/ack/data  instruction fetch handshake (addr = PC)
//   rf_ra/rb, rf_a/b        register-file reads (rd, rs) during DECODE
//   rf_we/wa/wd             register-file write, one EXEC cycle of an ALU op
//   alu_*                   ALU operands out, result and flags in
//   flag_z_o, flag_c_o      registered flags
//   halted_o                core stopped by HLT (only reset restarts it)
//   illegal_o               one-cycle pulse when an undefined op executes
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,

    output logic [1:0]         rf_ra_o,
    output logic [1:0]         rf_rb_o,
    input  logic [7:0]         rf_a_i,
    input  logic [7:0]         rf_b_i,
    output logic               rf_we_o,
    output logic [1:0]         rf_wa_o,
    output logic [7:0]         rf_wd_o,

    output logic [2:0]         alu_func_o,
    output logic [7:0]         alu_a_imm_o,
    output logic [7:0]         alu_a_mem_o,
    output logic [7:0]         alu_b_o,
    input  logic [7:0]         alu_result_i,
    input  logic               alu_fz_i,
    input  logic               alu_fc_i,

    output logic               flag_z_o,
    output logic               flag_c_o,
    output logic               halted_o,
    output logic               illegal_o
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [7:0]           a_q, a_d;
    logic [7:0]           b_q, b_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;

    logic                 is_alu, is_branch, is_halt, is_illegal;
    br_cond_e             branch_cond;
    logic                 br_taken;
    logic                 in_exec;
    logic [PC_W-1:0]      pc_inc, pc_imm;

    ctrl_decode u_decode (
        .op_i          (instr_op(ir_q)),
        .is_alu_o      (is_alu),
        .is_branch_o   (is_branch),
        .branch_cond_o (branch_cond),
        .is_halt_o     (is_halt),
        .is_illegal_o  (is_illegal)
    );

    assign pc_inc  = pc_q + PC_W'(1);        // wraps silently at the top
    assign pc_imm  = PC_W'(instr_imm(ir_q));
    assign in_exec = (state_q == ST_EXEC);

    always_comb begin
        case (branch_cond)
            BR_ALWAYS: br_taken = 1'b1;
            BR_Z:      br_taken = z_q;
            BR_C:      br_taken = c_q;
            default:   br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = rf_a_i;
                b_d     = rf_b_i;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (is_alu) begin
                    // Flags land at the end of EXEC, so a branch that
                    // immediately follows already sees them.
                    z_d = alu_fz_i;
                    c_d = alu_fc_i;
                end
                if (is_branch && br_taken) begin
                    pc_d = pc_imm;
                end
                if (is_halt) begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
            end
            default: ;  // ST_HALT: parked until reset
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    // Reset parks the state in FETCH, so request/write/illegal are also
    // qualified by rst_ni: they must drop the instant reset asserts and
    // stay low for its whole duration.
    assign imem_req_o  = rst_ni && (state_q == ST_FETCH);
    assign imem_addr_o = pc_q;

    assign rf_ra_o     = instr_rd(ir_q);
    assign rf_rb_o     = instr_rs(ir_q);
    assign rf_we_o     = rst_ni && in_exec && is_alu;
    assign rf_wa_o     = instr_rd(ir_q);
    assign rf_wd_o     = rf_we_o ? alu_result_i : 8'h00;

    assign alu_func_o  = ir_q[OP_LO+2:OP_LO];
    assign alu_a_imm_o = instr_imm(ir_q);
    assign alu_a_mem_o = a_q;
    assign alu_b_o     = b_q;

    assign flag_z_o    = z_q;
    assign flag_c_o    = c_q;
    assign halted_o    = (state_q == ST_HALT);
    assign illegal_o   = rst_ni && in_exec && is_illegal;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit. The bench plays instruction memory,
// register file and ALU; an ISA-level model predicts fetch addresses,
// write-backs and flags, which go through scoreboard queues.
module tb_ctrl_unit;
    import ctrl_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0;
    logic [1:0]  rf_ra, rf_rb, rf_wa;
    logic [7:0]  rf_a, rf_b, rf_wd;
    logic        rf_we;
    logic [2:0]  alu_func;
    logic [7:0]  alu_a_imm, alu_a_mem, alu_b, alu_result;
    logic        alu_fz, alu_fc;
    logic        flag_z, flag_c, halted, illegal;

    always #5 clk = ~clk;

    ctrl_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_data_i(imem_data),
        .rf_ra_o(rf_ra), .rf_rb_o(rf_rb), .rf_a_i(rf_a), .rf_b_i(rf_b),
        .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
        .alu_func_o(alu_func), .alu_a_imm_o(alu_a_imm), .alu_a_mem_o(alu_a_mem),
        .alu_b_o(alu_b), .alu_result_i(alu_result), .alu_fz_i(alu_fz), .alu_fc_i(alu_fc),
        .flag_z_o(flag_z), .flag_c_o(flag_c), .halted_o(halted), .illegal_o(illegal)
    );

    // Register file and ALU models
    logic [7:0] rf [4];
    assign rf_a = rf[rf_ra];
    assign rf_b = rf[rf_rb];

    function automatic logic [9:0] alu_ref(input logic [2:0] f, input logic [7:0] ai,
                                           input logic [7:0] am, input logic [7:0] b);
        logic [8:0] w;
        w = '0;
        case (f)
            FN_ADI:  w = {1'b0, ai} + {1'b0, b};
            FN_ADD:  w = {1'b0, am} + {1'b0, b};
            FN_SUB:  w = {1'b0, am} - {1'b0, b};
            FN_AND:  w = {1'b0, am & b};
            FN_OR:   w = {1'b0, am | b};
            FN_XOR:  w = {1'b0, am ^ b};
            FN_SHL:  w = {am, 1'b0};
            default: w = {am[0], 1'b0, am[7:1]};
        endcase
        return {(w[7:0] == 8'h00), w[8], w[7:0]};
    endfunction

    always_comb {alu_fz, alu_fc, alu_result} = alu_ref(alu_func, alu_a_imm, alu_a_mem, alu_b);

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       ill;
        logic [2:0] fn;
        logic [7:0] imm;
        logic [7:0] a;
        logic [7:0] b;
    } exec_exp_t;

    exec_exp_t  exec_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] m_pc;
    logic       m_z, m_c;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_z  = 1'b0;
        m_c  = 1'b0;
        addr_q.delete();
        exec_q.delete();
        addr_q.push_back(8'h00);
    endtask

    // Runs one instruction starting from a negedge; returns at a negedge.
    // rst_exec asserts reset in the middle of EXEC instead of completing it.
    task automatic step(input logic [15:0] ins, input int waits, input bit rst_exec);
        exec_exp_t  e;
        exec_exp_t  got;
        logic [7:0] ea;
        logic [9:0] r;
        logic [3:0] op;
        int         t;
        int         held;
        op = ins[15:12];
        t  = 0;
        while (!imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("fetch_req_seen", (t < 50), 1);
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 8'hxx;
        chk("fetch_addr", imem_addr, ea);
        held = 0;
        for (int i = 0; i < waits; i++) begin
            if (imem_req && imem_addr == ea) held++;
            @(negedge clk);
        end
        chk("req_held_waits", held, waits);
        chk("req_at_ack", {imem_req, imem_addr}, {1'b1, ea});
        // Expected execution, predicted from the register file as it is now
        e.a   = rf[ins[11:10]];
        e.b   = rf[ins[9:8]];
        r     = alu_ref(op[2:0], ins[7:0], e.a, e.b);
        e.we  = !op[3];
        e.wa  = ins[11:10];
        e.wd  = e.we ? r[7:0] : 8'h00;
        e.ill = (op >= 4'hD);
        e.fn  = op[2:0];
        e.imm = ins[7:0];
        exec_q.push_back(e);
        imem_ack  = 1'b1;
        imem_data = ins;
        @(posedge clk);
        #1;
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        @(negedge clk);
        chk("decode_req", imem_req, 0);
        chk("decode_ra_rb", {rf_ra, rf_rb}, {ins[11:10], ins[9:8]});
        @(negedge clk);
        got = exec_q.pop_front();
        chk("exec_we", rf_we, got.we);
        chk("exec_wa_wd", {rf_wa, rf_wd}, got.we ? {got.wa, got.wd} : {rf_wa, 8'h00});
        chk("exec_illegal", illegal, got.ill);
        chk("exec_alu_ops", {alu_func, alu_a_imm, alu_a_mem, alu_b},
            {got.fn, got.imm, got.a, got.b});
        if (rst_exec) begin
            rst_n = 1'b0;
            #1;
            chk("rst_exec_we", rf_we, 0);
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            return;
        end
        // Advance the ISA model
        if (got.we) begin
            rf[got.wa] = got.wd;
            m_z = r[9];
            m_c = r[8];
        end
        case (op)
            OP_JMP:  m_pc = ins[7:0];
            OP_BRZ:  m_pc = m_z ? ins[7:0] : m_pc + 8'd1;
            OP_BRC:  m_pc = m_c ? ins[7:0] : m_pc + 8'd1;
            OP_HLT:  m_pc = m_pc;
            default: m_pc = m_pc + 8'd1;
        endcase
        if (op != OP_HLT) addr_q.push_back(m_pc);
        @(negedge clk);
        chk("post_flags", {flag_z, flag_c}, {m_z, m_c});
        chk("post_pulses", {rf_we, illegal}, 2'b00);
        chk("post_halted", halted, (op == OP_HLT));
    endtask

    initial begin
        int reqs;
        rf[0] = 8'h00; rf[1] = 8'h00; rf[2] = 8'h20; rf[3] = 8'h33;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_we_ill_halt", {imem_req, rf_we, illegal, halted}, 4'b0000);
        chk("rst_addr_flags", {imem_addr, flag_z, flag_c}, 10'h000);
        chk("rst_alu_outs", {alu_func, alu_a_imm, alu_a_mem, alu_b, rf_wd}, '0);
        rst_n = 1'b1;

        step(16'h06F0, 2, 0);   // ADI r1 = 0xF0 + r2(0x20) -> 0x10, C=1
        step(16'h2F00, 0, 0);   // SUB r3 - r3 -> 0, Z=1
        step(16'h9040, 0, 0);   // BRZ 0x40 taken
        step(16'h3600, 0, 0);   // AND r1 & r2 -> 0, C=0
        step(16'hA080, 0, 0);   // BRC 0x80 not taken
        step(16'h02FF, 1, 0);   // ADI r0 = 0xFF + 0x20 -> carry
        step(16'hA090, 0, 0);   // BRC 0x90 taken
        step(16'h9010, 0, 0);   // BRZ not taken (Z=0)
        step(16'hE5AA, 0, 0);   // illegal opcode -> NOP
        step(16'hB000, 0, 0);   // NOP
        step(16'h80FF, 0, 0);   // JMP 0xFF
        step(16'hB000, 0, 0);   // NOP at 0xFF wraps to 0x00
        step(16'h5B00, 3, 0);   // XOR r2 ^ r3

        // Reset while a fetch is outstanding, with ack arriving in reset
        chk("pre_rst_fetch_req", imem_req, 1);
        imem_ack  = 1'b1;
        imem_data = 16'h8077;
        rst_n     = 1'b0;
        #1;
        chk("rst_fetch_req_drop", imem_req, 0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        chk("rst_fetch_flags", {flag_z, flag_c}, 2'b00);

        step(16'h1000, 0, 0);   // ADD r0 + r0, fetched from RESET_PC
        step(16'h6A00, 1, 1);   // SHL r2, aborted by reset in EXEC
        chk("rst_exec_flags", {flag_z, flag_c}, 2'b00);
        step(16'h7000, 0, 0);   // SHR r0, fetched from RESET_PC again
        step(16'hC000, 0, 0);   // HLT

        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req || !halted) reqs++;
            @(negedge clk);
        end
        chk("halt_no_fetch_20cyc", reqs, 0);
        chk("halt_pc_held", imem_addr, m_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
